// File: rtl/wbu_commit.sv
// In-order commit buffer for the NPC writeback stage: retires one entry per cycle,
// decodes exceptions, squashes on trap/mret, and tracks retire/halt/watchdog status.
module wbu_commit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_EXCP = 16,
  parameter int unsigned BRK_BIT  = 3,
  parameter int unsigned TIMEOUT  = 32'h2000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_gr_we,
  input  logic [4:0]          in_rd,
  input  logic [XLEN-1:0]     in_result,
  input  logic                in_csr_we,
  input  logic [11:0]         in_csr_addr,
  input  logic [XLEN-1:0]     in_csr_wdata,
  input  logic                in_xret,
  input  logic [NUM_EXCP-1:0] in_excp,
  input  logic                commit_ready,
  output logic                rf_we_o,
  output logic [4:0]          rf_rd_o,
  output logic [XLEN-1:0]     rf_wdata_o,
  output logic                csr_we_o,
  output logic [11:0]         csr_addr_o,
  output logic [XLEN-1:0]     csr_wdata_o,
  output logic [XLEN-1:0]     csr_mcause_o,
  output logic [XLEN-1:0]     csr_mepc_o,
  output logic                excp_flush,
  output logic                mret_flush,
  output logic                retire_valid,
  output logic [XLEN-1:0]     retire_count,
  output logic                halt_o,
  output logic                watchdog_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned IW = 32;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic                gr_we;
    logic [4:0]          rd;
    logic [XLEN-1:0]     result;
    logic                csr_we;
    logic [11:0]         csr_addr;
    logic [XLEN-1:0]     csr_wdata;
    logic                xret;
    logic [NUM_EXCP-1:0] excp;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] retire_count_q, retire_count_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            halt_q, halt_d;
  logic            watchdog_q, watchdog_d;

  entry_t          in_entry_c;
  entry_t          head_c;
  logic            empty_c, full_c;
  logic            head_excp_c;
  logic            push_c, pop_c, squash_c;

  // Occupancy, head decode and combinational write-port outputs.
  always_comb begin
    in_entry_c   = '{pc: in_pc, gr_we: in_gr_we, rd: in_rd, result: in_result,
                     csr_we: in_csr_we, csr_addr: in_csr_addr, csr_wdata: in_csr_wdata,
                     xret: in_xret, excp: in_excp};
    empty_c      = (wr_ptr_q == rd_ptr_q);
    full_c       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    head_c       = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    head_excp_c  = |head_c.excp;
    retire_valid = !empty_c && commit_ready;
    in_ready     = !full_c || retire_valid;
    push_c       = in_valid && in_ready;
    pop_c        = retire_valid;

    rf_we_o      = retire_valid && head_c.gr_we && !head_excp_c;
    rf_rd_o      = head_c.rd;
    rf_wdata_o   = head_c.result;
    csr_we_o     = retire_valid && head_c.csr_we && !head_excp_c;
    csr_addr_o   = head_c.csr_addr;
    csr_wdata_o  = head_c.csr_wdata;
    csr_mepc_o   = head_c.pc;
    excp_flush   = retire_valid && head_excp_c;
    mret_flush   = retire_valid && head_c.xret && !head_excp_c;
    squash_c     = excp_flush || mret_flush;

    // Scan from the top so the lowest set bit wins.
    csr_mcause_o = '0;
    for (int i = NUM_EXCP - 1; i >= 0; i--) begin
      if (head_c.excp[i]) csr_mcause_o = XLEN'(unsigned'(i));
    end

    retire_count = retire_count_q;
    halt_o       = halt_q;
    watchdog_o   = watchdog_q;
  end

  // Next-state: pointers, storage, counters and sticky flags.
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    retire_count_d = retire_count_q;
    idle_d         = idle_q;
    halt_d         = halt_q;
    watchdog_d     = watchdog_q;

    if (push_c) mem_d[wr_ptr_q[AW-1:0]] = in_entry_c;

    // A trapping retirement discards everything younger, including this cycle's push.
    if (squash_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (pop_c) begin
      retire_count_d = retire_count_q + XLEN'(1);
      idle_d         = '0;
      if (head_c.excp[BRK_BIT]) halt_d = 1'b1;
    end else if (idle_q < IW'(TIMEOUT)) begin
      idle_d = idle_q + IW'(1);
    end

    if (idle_d == IW'(TIMEOUT)) watchdog_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      retire_count_q <= '0;
      idle_q         <= '0;
      halt_q         <= 1'b0;
      watchdog_q     <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      retire_count_q <= retire_count_d;
      idle_q         <= idle_d;
      halt_q         <= halt_d;
      watchdog_q     <= watchdog_d;
    end
  end

endmodule

// File: tb/tb_wbu_commit.sv
// Self-checking bench for wbu_commit: a negedge scoreboard models the buffer,
// while per-feature tasks check latency, backpressure, squash, priority, watchdog and reset.
module tb_wbu_commit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NEXC  = 16;
  localparam int unsigned TMO   = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc = '0;
  logic             in_gr_we = 1'b0;
  logic [4:0]       in_rd = '0;
  logic [XLEN-1:0]  in_result = '0;
  logic             in_csr_we = 1'b0;
  logic [11:0]      in_csr_addr = '0;
  logic [XLEN-1:0]  in_csr_wdata = '0;
  logic             in_xret = 1'b0;
  logic [NEXC-1:0]  in_excp = '0;
  logic             commit_ready = 1'b0;
  logic             rf_we_o;
  logic [4:0]       rf_rd_o;
  logic [XLEN-1:0]  rf_wdata_o;
  logic             csr_we_o;
  logic [11:0]      csr_addr_o;
  logic [XLEN-1:0]  csr_wdata_o;
  logic [XLEN-1:0]  csr_mcause_o;
  logic [XLEN-1:0]  csr_mepc_o;
  logic             excp_flush;
  logic             mret_flush;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_count;
  logic             halt_o;
  logic             watchdog_o;

  int checks = 0;
  int errors = 0;

  wbu_commit #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_EXCP(NEXC), .BRK_BIT(3), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_gr_we(in_gr_we), .in_rd(in_rd), .in_result(in_result),
    .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
    .in_xret(in_xret), .in_excp(in_excp), .commit_ready(commit_ready),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o),
    .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
    .csr_mcause_o(csr_mcause_o), .csr_mepc_o(csr_mepc_o),
    .excp_flush(excp_flush), .mret_flush(mret_flush),
    .retire_valid(retire_valid), .retire_count(retire_count),
    .halt_o(halt_o), .watchdog_o(watchdog_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            gr_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            xret;
    logic [NEXC-1:0] excp;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] exp_count = '0;

  function automatic logic [XLEN-1:0] low_bit(input logic [NEXC-1:0] x);
    for (int i = 0; i < NEXC; i++) if (x[i]) return XLEN'(i);
    return '0;
  endfunction

  // Scoreboard: predicts handshake, compares the head on retirement, then books the new push.
  always @(negedge clock) begin : mon
    exp_t h;
    logic exp_rv, exp_ir, trap, has_exc;
    if (reset) begin
      sb.delete();
      exp_count = '0;
    end else begin
      exp_rv = (sb.size() > 0) && commit_ready;
      exp_ir = (sb.size() < DEPTH) || exp_rv;
      trap   = 1'b0;
      checks++; if (retire_valid !== exp_rv) begin errors++; $display("FAIL retire_valid got %0b exp %0b t=%0t", retire_valid, exp_rv, $time); end
      checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL in_ready got %0b exp %0b t=%0t", in_ready, exp_ir, $time); end
      checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL retire_count got %0d exp %0d t=%0t", retire_count, exp_count, $time); end
      if (sb.size() > 0) begin
        h = sb[0];
        checks++;
        if (rf_rd_o !== h.rd || rf_wdata_o !== h.result || csr_mepc_o !== h.pc)
          begin errors++; $display("FAIL head_fields got rd=%0d d=%h pc=%h exp rd=%0d d=%h pc=%h", rf_rd_o, rf_wdata_o, csr_mepc_o, h.rd, h.result, h.pc); end
      end
      if (exp_rv) begin
        has_exc = (h.excp != '0);
        checks++;
        if (rf_we_o !== (h.gr_we && !has_exc) || csr_we_o !== (h.csr_we && !has_exc))
          begin errors++; $display("FAIL retire_we rd=%0d got rf=%0b csr=%0b exp rf=%0b csr=%0b", h.rd, rf_we_o, csr_we_o, h.gr_we && !has_exc, h.csr_we && !has_exc); end
        checks++;
        if (excp_flush !== has_exc || mret_flush !== (h.xret && !has_exc) || csr_mcause_o !== low_bit(h.excp))
          begin errors++; $display("FAIL retire_trap rd=%0d got ef=%0b mf=%0b mc=%0d exp ef=%0b mf=%0b mc=%0d", h.rd, excp_flush, mret_flush, csr_mcause_o, has_exc, h.xret && !has_exc, low_bit(h.excp)); end
        if (h.csr_we && !has_exc) begin
          checks++;
          if (csr_addr_o !== h.csr_addr || csr_wdata_o !== h.csr_wdata)
            begin errors++; $display("FAIL csr_port got a=%h d=%h exp a=%h d=%h", csr_addr_o, csr_wdata_o, h.csr_addr, h.csr_wdata); end
        end
        trap = has_exc || h.xret;
        void'(sb.pop_front());
        exp_count = exp_count + 1;
        if (trap) sb.delete();
      end else begin
        checks++;
        if (rf_we_o !== 1'b0 || csr_we_o !== 1'b0 || excp_flush !== 1'b0 || mret_flush !== 1'b0)
          begin errors++; $display("FAIL idle_we got rf=%0b csr=%0b ef=%0b mf=%0b exp 0", rf_we_o, csr_we_o, excp_flush, mret_flush); end
      end
      if (in_valid && exp_ir && !trap) begin
        h = '{pc: in_pc, gr_we: in_gr_we, rd: in_rd, result: in_result, csr_we: in_csr_we,
              csr_addr: in_csr_addr, csr_wdata: in_csr_wdata, xret: in_xret, excp: in_excp};
        sb.push_back(h);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [XLEN-1:0] res, input logic [XLEN-1:0] pc,
                       input logic [NEXC-1:0] excp, input logic xret, input logic csr_we);
    in_valid     = 1'b1;
    in_gr_we     = 1'b1;
    in_rd        = rd;
    in_result    = res;
    in_pc        = pc;
    in_excp      = excp;
    in_xret      = xret;
    in_csr_we    = csr_we;
    in_csr_addr  = 12'h300 + 12'(rd);
    in_csr_wdata = res ^ 32'hA5A5_0000;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_excp   = '0;
    in_xret   = 1'b0;
    in_csr_we = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || retire_valid !== 1'b0) begin errors++; $display("FAIL reset_hs got ir=%0b rv=%0b exp 1 0", in_ready, retire_valid); end
    checks++; if (retire_count !== '0 || halt_o !== 1'b0 || watchdog_o !== 1'b0) begin errors++; $display("FAIL reset_status got rc=%0d h=%0b w=%0b exp 0", retire_count, halt_o, watchdog_o); end
    checks++; if (rf_wdata_o !== '0 || csr_mepc_o !== '0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_data got d=%h pc=%h we=%0b exp 0", rf_wdata_o, csr_mepc_o, rf_we_o); end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    commit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(5'(i + 1), 32'h10 + 32'(i), 32'h8000_0100 + 32'(4 * i), '0, 1'b0, i == 2);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got %0b exp 1", i, in_ready); end
      step();
      checks++;
      if (retire_valid !== 1'b1 || rf_we_o !== 1'b1 || rf_rd_o !== 5'(i + 1))
        begin errors++; $display("FAIL stream_latency i=%0d got rv=%0b we=%0b rd=%0d exp 1 1 %0d", i, retire_valid, rf_we_o, rf_rd_o, i + 1); end
    end
    idle();
    step(); step();
    checks++; if (retire_count !== 32'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", retire_count); end
  endtask

  task automatic test_backpressure();
    commit_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(5'(5 + i), 32'h50 + 32'(i), 32'h8000_0200 + 32'(4 * i), '0, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready i=%0d got %0b exp %0b", i, in_ready, i < 4); end
      step();
    end
    commit_ready = 1'b1;
    for (int i = 4; i < 6; i++) begin
      drive(5'(5 + i), 32'h50 + 32'(i), 32'h8000_0200 + 32'(4 * i), '0, 1'b0, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1 || retire_valid !== 1'b1 || rf_rd_o !== 5'(1 + i))
        begin errors++; $display("FAIL bp_pushpop i=%0d got ir=%0b rv=%0b rd=%0d exp 1 1 %0d", i, in_ready, retire_valid, rf_rd_o, 1 + i); end
      step();
    end
    idle();
    repeat (5) step();
    checks++; if (retire_count !== 32'd10) begin errors++; $display("FAIL bp_count got %0d exp 10", retire_count); end
  endtask

  task automatic test_squash();
    commit_ready = 1'b0;
    drive(5'd11, 32'h111, 32'h8000_0004, 16'h0004, 1'b0, 1'b1); step();
    drive(5'd12, 32'h222, 32'h8000_0008, '0, 1'b0, 1'b0); step();
    drive(5'd13, 32'h333, 32'h8000_000C, '0, 1'b0, 1'b0); step();
    drive(5'd14, 32'h444, 32'h8000_0010, '0, 1'b0, 1'b0);
    commit_ready = 1'b1;
    #1;
    checks++;
    if (excp_flush !== 1'b1 || csr_mcause_o !== 32'd2 || csr_mepc_o !== 32'h8000_0004 || rf_we_o !== 1'b0 || csr_we_o !== 1'b0)
      begin errors++; $display("FAIL squash_trap got ef=%0b mc=%0d pc=%h we=%0b exp 1 2 80000004 0", excp_flush, csr_mcause_o, csr_mepc_o, rf_we_o); end
    step();
    idle();
    #1;
    checks++;
    if (retire_valid !== 1'b0 || in_ready !== 1'b1 || excp_flush !== 1'b0)
      begin errors++; $display("FAIL squash_empty got rv=%0b ir=%0b ef=%0b exp 0 1 0", retire_valid, in_ready, excp_flush); end
    repeat (3) step();
    checks++; if (retire_count !== 32'd11) begin errors++; $display("FAIL squash_count got %0d exp 11", retire_count); end
  endtask

  task automatic test_priority();
    commit_ready = 1'b1;
    drive(5'd15, 32'h555, 32'h8000_0400, 16'h0808, 1'b1, 1'b0);
    step();
    idle();
    checks++;
    if (csr_mcause_o !== 32'd3 || excp_flush !== 1'b1 || mret_flush !== 1'b0 || rf_we_o !== 1'b0)
      begin errors++; $display("FAIL prio_trap got mc=%0d ef=%0b mf=%0b we=%0b exp 3 1 0 0", csr_mcause_o, excp_flush, mret_flush, rf_we_o); end
    step();
    checks++; if (halt_o !== 1'b1 || excp_flush !== 1'b0) begin errors++; $display("FAIL prio_halt got h=%0b ef=%0b exp 1 0", halt_o, excp_flush); end
    drive(5'd16, 32'h666, 32'h8000_0500, '0, 1'b1, 1'b0);
    step();
    idle();
    checks++;
    if (mret_flush !== 1'b1 || excp_flush !== 1'b0 || rf_we_o !== 1'b1)
      begin errors++; $display("FAIL xret_flush got mf=%0b ef=%0b we=%0b exp 1 0 1", mret_flush, excp_flush, rf_we_o); end
    step();
    checks++; if (halt_o !== 1'b1 || mret_flush !== 1'b0) begin errors++; $display("FAIL halt_sticky got h=%0b mf=%0b exp 1 0", halt_o, mret_flush); end
  endtask

  task automatic test_watchdog();
    idle();
    commit_ready = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++; if (watchdog_o !== (k >= TMO)) begin errors++; $display("FAIL watchdog k=%0d got %0b exp %0b", k, watchdog_o, k >= TMO); end
    end
    drive(5'd17, 32'h777, 32'h8000_0600, '0, 1'b0, 1'b0);
    step();
    idle();
    step();
    checks++; if (watchdog_o !== 1'b1 || retire_count !== 32'd1) begin errors++; $display("FAIL watchdog_sticky got w=%0b rc=%0d exp 1 1", watchdog_o, retire_count); end
  endtask

  task automatic test_async_reset();
    commit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'(20 + i), 32'h900 + 32'(i), 32'h8000_0700 + 32'(4 * i), '0, 1'b0, 1'b0);
      step();
    end
    idle();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || retire_valid !== 1'b0 || rf_rd_o !== '0 || rf_wdata_o !== '0 || csr_mepc_o !== '0)
      begin errors++; $display("FAIL async_reset_buf got ir=%0b rv=%0b rd=%0d d=%h pc=%h exp 1 0 0 0 0", in_ready, retire_valid, rf_rd_o, rf_wdata_o, csr_mepc_o); end
    checks++;
    if (retire_count !== '0 || watchdog_o !== 1'b0 || halt_o !== 1'b0)
      begin errors++; $display("FAIL async_reset_status got rc=%0d w=%0b h=%0b exp 0", retire_count, watchdog_o, halt_o); end
    commit_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (4) step();
    checks++; if (retire_count !== '0 || rf_we_o !== 1'b0) begin errors++; $display("FAIL async_reset_after got rc=%0d we=%0b exp 0 0", retire_count, rf_we_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_squash();
    test_priority();
    test_watchdog();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
